block_serializer: RTL

BLOCK_SERIALIZER -- requirements
Module: block_serializer

---
 rtl/block_serializer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/block_serializer.sv
// block_serializer
//   Accepts a whole block of WORDS words on a valid/ready input and emits the
//   words one at a time on a valid/ready output, in row-major or column-major
//   order (COL_MAJOR). All outputs are registered.
//
//   Parameters:
//     WORD_W    width of one output word in bits
//     WORDS     words per block (>= 2)
//     COL_MAJOR 0 = row-major emit order, 1 = column-major (WORDS must be N*N)
//
//   Ports:
//     clk        sole clock, rising edge
//     rst        synchronous active-high reset
//     in_valid   in_block holds a valid block
//     in_ready   block accepted when in_valid && in_ready at a clk edge
//     in_block   block; word j = in_block[(WORDS-j)*WORD_W-1 -: WORD_W] (word 0 = MSBs)
//     out_valid  out_word is valid
//     out_ready  word transferred when out_valid && out_ready at a clk edge
//     out_word   current word
//     out_idx    emit position k of out_word
//     out_first  asserted with k == 0
//     out_last   asserted with k == WORDS-1
//
//   Optional build macro:
//     BLOCK_SERIALIZER_SKID_EN  adds a one-block skid register so the next block
//                               can be accepted while the current one is emitted,
//                               giving back-to-back blocks with no idle cycle.

module block_serializer #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned WORDS     = 16,
  parameter int unsigned COL_MAJOR = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W*WORDS-1:0]    in_block,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_word,
  output logic [$clog2(WORDS)-1:0]   out_idx,
  output logic                       out_first,
  output logic                       out_last
);

  localparam int unsigned BLK_W = WORD_W * WORDS;
  localparam int unsigned IDXW  = $clog2(WORDS);

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i * i <= v; i++) r = i;
    return r;
  endfunction

  localparam int unsigned N = isqrt(WORDS);

  if (WORDS < 2) begin : g_words_chk
    $error("block_serializer: WORDS must be >= 2");
  end

  if (COL_MAJOR != 0 && N * N != WORDS) begin : g_square_chk
    $error("block_serializer: COL_MAJOR=1 requires WORDS to be a perfect square");
  end

  // Word j sits at the MSB end after shifting the block left by j words,
  // which avoids a variable-width part-select index.
  function automatic logic [WORD_W-1:0] sel_word(input logic [BLK_W-1:0] b,
                                                  input logic [IDXW-1:0]  pos);
    int unsigned      p;
    int unsigned      j;
    logic [BLK_W-1:0] sh;
    p = 32'(pos);
    if (COL_MAJOR != 0) j = (p % N) * N + (p / N);
    else                j = p;
    sh = b << (j * WORD_W);
    return sh[BLK_W-1 -: WORD_W];
  endfunction

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t           state;
  logic [BLK_W-1:0] main_blk;
  logic             accept;
  logic             xfer;
  logic             at_last;
  logic [IDXW-1:0]  nxt_idx;

`ifdef BLOCK_SERIALIZER_SKID_EN
  logic [BLK_W-1:0] skid_blk;
  logic             skid_full;
`endif

  always_comb begin
    accept  = in_valid && in_ready;
    xfer    = out_valid && out_ready;
    at_last = (out_idx == IDXW'(WORDS - 1));
    nxt_idx = out_idx + IDXW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      main_blk  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_word  <= '0;
      in_ready  <= 1'b1;
`ifdef BLOCK_SERIALIZER_SKID_EN
      skid_blk  <= '0;
      skid_full <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            main_blk  <= in_block;
            state     <= EMIT;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_word  <= sel_word(in_block, '0);
            out_first <= 1'b1;
            out_last  <= 1'b0;
`ifdef BLOCK_SERIALIZER_SKID_EN
            in_ready  <= 1'b1;
`else
            in_ready  <= 1'b0;
`endif
          end
        end

        EMIT: begin
          if (xfer && at_last) begin
`ifdef BLOCK_SERIALIZER_SKID_EN
            if (skid_full) begin
              // Promote the buffered block with no bubble; a same-edge accept
              // refills the skid.
              main_blk  <= skid_blk;
              out_idx   <= '0;
              out_word  <= sel_word(skid_blk, '0);
              out_first <= 1'b1;
              out_last  <= 1'b0;
              skid_full <= accept;
              in_ready  <= !accept;
              if (accept) skid_blk <= in_block;
            end else if (accept) begin
              // Skid empty but a block arrives on the final transfer: load it
              // straight into the main register so emission continues.
              main_blk  <= in_block;
              out_idx   <= '0;
              out_word  <= sel_word(in_block, '0);
              out_first <= 1'b1;
              out_last  <= 1'b0;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
            end
`else
            state     <= IDLE;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            in_ready  <= 1'b1;
`endif
          end else begin
            if (xfer) begin
              out_idx   <= nxt_idx;
              out_word  <= sel_word(main_blk, nxt_idx);
              out_first <= 1'b0;
              out_last  <= (nxt_idx == IDXW'(WORDS - 1));
            end
`ifdef BLOCK_SERIALIZER_SKID_EN
            if (accept) begin
              skid_blk  <= in_block;
              skid_full <= 1'b1;
              in_ready  <= 1'b0;
            end
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
